// File: rtl/fixed_to_double_seq.sv
// Iterative fixed-point Q(N_BITS_INT.N_BITS_FRAC) to IEEE-754 double converter.
// Round-to-nearest-even, multi-bit-per-cycle normaliser, valid/ready on both sides.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// ABS   | take magnitude of the latched input, short-cut zero
// NORM  | shift left up to SHIFT_STEP bits per cycle until MSB is set
// ROUND | build exponent/mantissa, round-to-nearest-even, register result
// DONE  | hold out_num/inexact with out_valid until out_ready
module fixed_to_double_seq #(
  parameter int N_BITS_INT  = 32,
  parameter int N_BITS_FRAC = 16,
  parameter int SHIFT_STEP  = 4,
  parameter bit SIGNED      = 1'b1,
  localparam int W          = N_BITS_INT + N_BITS_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_num,
  output logic         inexact
);

  localparam int CW       = $clog2(W + 1);
  localparam int EXP_BASE = 1023 + (W - 1 - N_BITS_FRAC);
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  generate
    if (W < 2 || W > 256) begin : g_bad_width
      $error("fixed_to_double_seq: N_BITS_INT+N_BITS_FRAC must be in 2..256");
    end
    if (SHIFT_STEP < 1 || SHIFT_STEP > W) begin : g_bad_step
      $error("fixed_to_double_seq: SHIFT_STEP must be in 1..W");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t        state;
  logic          sign_r;
  logic [W-1:0]  mag;
  logic [CW-1:0] shcnt;

  logic [CW-1:0] lz;
  logic [CW-1:0] step_k;
  logic [W-1:0]  mag_sh;
  logic [W-1:0]  mag_abs;
  logic [W+52:0] padded;
  logic [51:0]   mant;
  logic          guard;
  logic          sticky;
  logic          round_up;
  logic [52:0]   mant_inc;
  logic [51:0]   mant_fin;
  logic [10:0]   exp_c;
  logic [10:0]   exp_fin;

  assign in_ready = (state == IDLE);

  // Leading-zero count of mag and the clamped per-cycle shift amount.
  always_comb begin
    lz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (mag[i]) lz = CW'(W - 1 - i);
    end
    step_k  = (lz > STEP) ? STEP : lz;
    mag_sh  = mag << step_k;
    mag_abs = sign_r ? (-mag) : mag;
  end

  // Rounding datapath; bits below the hidden bit are left-justified against
  // zero padding so narrow inputs fall out as exact with no special case.
  always_comb begin
    padded   = {mag[W-2:0], 54'd0};
    mant     = padded[W+52 -: 52];
    guard    = padded[W];
    sticky   = |padded[W-1:0];
    round_up = guard && (sticky || mant[0]);
    mant_inc = {1'b0, mant} + 53'd1;
    mant_fin = round_up ? mant_inc[51:0] : mant;
    // Result always lies in 1..2046, so 11-bit modular arithmetic is exact.
    exp_c    = 11'(EXP_BASE) - 11'(shcnt);
    exp_fin  = exp_c + 11'(round_up && mant_inc[52]);
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sign_r    <= 1'b0;
      mag       <= '0;
      shcnt     <= '0;
      out_valid <= 1'b0;
      out_num   <= 64'd0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= SIGNED ? num[W-1] : 1'b0;
            mag    <= num;
            state  <= ABS;
          end
        end
        ABS: begin
          if (mag_abs == '0) begin
            out_num   <= 64'd0;
            inexact   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mag   <= mag_abs;
            shcnt <= '0;
            state <= NORM;
          end
        end
        NORM: begin
          mag   <= mag_sh;
          shcnt <= shcnt + step_k;
          if (mag_sh[W-1]) state <= ROUND;
        end
        ROUND: begin
          out_num   <= {sign_r, exp_fin, mant_fin};
          inexact   <= guard | sticky;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_double_seq.sv
// Directed bench for fixed_to_double_seq: default signed Q32.16 instance plus
// an unsigned 64-bit integer instance for the rounding cases.
module tb_fixed_to_double_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_inexact;
  logic [47:0] a_num = '0;
  logic [63:0] a_out_num;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_inexact;
  logic [63:0] b_num = '0;
  logic [63:0] b_out_num;

  int n_checks = 0;
  int n_fail   = 0;

  fixed_to_double_seq dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .num(a_num),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_num(a_out_num), .inexact(a_inexact)
  );

  fixed_to_double_seq #(.N_BITS_INT(64), .N_BITS_FRAC(0), .SHIFT_STEP(4), .SIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .num(b_num),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_num(b_out_num), .inexact(b_inexact)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present v, wait for the accept edge, then count cycles until out_valid.
  task automatic run_a(input logic [47:0] v, output logic [63:0] res, output logic ix, output int lat);
    @(negedge clk);
    a_num = v; a_in_valid = 1'b1;
    check("a_in_ready_before_accept", 64'(a_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = a_out_num; ix = a_inexact;
  endtask

  task automatic ack_a();
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("a_out_valid_after_ack", 64'(a_out_valid), 64'd0);
    check("a_in_ready_after_ack", 64'(a_in_ready), 64'd1);
  endtask

  task automatic run_b(input logic [63:0] v, output logic [63:0] res, output logic ix, output int lat);
    @(negedge clk);
    b_num = v; b_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = b_out_num; ix = b_inexact;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    logic        x;
    int          l;
    logic        seen;

    // Reset state
    #12;
    check("reset_out_valid", 64'(a_out_valid), 64'd0);
    check("reset_out_num", a_out_num, 64'd0);
    check("reset_inexact", 64'(a_inexact), 64'd0);
    check("reset_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1.0: lz0=31, n=8, latency 10
    run_a(48'h0000_0001_0000, r, x, l);
    check("one_out_num", r, 64'h3FF0_0000_0000_0000);
    check("one_inexact", 64'(x), 64'd0);
    check("one_latency", 64'(l), 64'd10);
    ack_a();

    // -2.5
    run_a(48'hFFFF_FFFD_8000, r, x, l);
    check("neg2p5_out_num", r, 64'hC004_0000_0000_0000);
    check("neg2p5_inexact", 64'(x), 64'd0);
    ack_a();

    // zero: short-cut, latency 1
    run_a(48'h0, r, x, l);
    check("zero_out_num", r, 64'd0);
    check("zero_latency", 64'(l), 64'd1);
    ack_a();

    // most negative value, lz0=0 so n=1
    run_a(48'h8000_0000_0000, r, x, l);
    check("minneg_out_num", r, 64'hC1E0_0000_0000_0000);
    check("minneg_latency", 64'(l), 64'd3);
    ack_a();

    // most positive value, lz0=1 so n=1
    run_a(48'h7FFF_FFFF_FFFF, r, x, l);
    check("maxpos_out_num", r, 64'h41DF_FFFF_FFFF_FFC0);
    check("maxpos_latency", 64'(l), 64'd3);
    ack_a();

    // 0.5
    run_a(48'h0000_0000_8000, r, x, l);
    check("half_out_num", r, 64'h3FE0_0000_0000_0000);
    check("half_latency", 64'(l), 64'd10);
    ack_a();

    // Backpressure: result held, new input ignored while DONE
    run_a(48'h0000_0001_0000, r, x, l);
    a_num = 48'h0000_0002_0000; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_num_stable", a_out_num, 64'h3FF0_0000_0000_0000);
      check("bp_in_ready_low", 64'(a_in_ready), 64'd0);
      check("bp_out_valid_high", 64'(a_out_valid), 64'd1);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("bp_idle_in_ready", 64'(a_in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    a_in_valid = 1'b0;
    check("bp_next_accepted", 64'(a_in_ready), 64'd0);
    l = 0;
    while (!a_out_valid && l < 200) begin
      @(negedge clk);
      l++;
    end
    check("bp_next_out_num", a_out_num, 64'h4000_0000_0000_0000);
    ack_a();

    // Reset during NORM aborts the conversion
    @(negedge clk);
    a_num = 48'h0000_0001_0000; a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_num", a_out_num, 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("rst_no_spurious_output", 64'(seen), 64'd0);
    run_a(48'hFFFF_FFFD_8000, r, x, l);
    check("rst_recover_out_num", r, 64'hC004_0000_0000_0000);
    ack_a();

    // Unsigned 64-bit rounding cases
    run_b(64'h0020_0000_0000_0001, r, x, l);
    check("b_tie_even_out_num", r, 64'h4340_0000_0000_0000);
    check("b_tie_even_inexact", 64'(x), 64'd1);
    check("b_tie_even_latency", 64'(l), 64'd5);
    run_b(64'h0020_0000_0000_0003, r, x, l);
    check("b_tie_up_out_num", r, 64'h4340_0000_0000_0002);
    check("b_tie_up_inexact", 64'(x), 64'd1);
    run_b(64'h003F_FFFF_FFFF_FFFF, r, x, l);
    check("b_carry_out_num", r, 64'h4350_0000_0000_0000);
    check("b_carry_inexact", 64'(x), 64'd1);
    run_b(64'h0020_0000_0000_0002, r, x, l);
    check("b_exact_out_num", r, 64'h4340_0000_0000_0001);
    check("b_exact_inexact", 64'(x), 64'd0);
    run_b(64'hFFFF_FFFF_FFFF_FFFF, r, x, l);
    check("b_allones_out_num", r, 64'h43F0_0000_0000_0000);
    check("b_allones_inexact", 64'(x), 64'd1);
    check("b_allones_latency", 64'(l), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
